// File: rtl/uart_pkg.sv
// Shared definitions for the UART Avalon-MM arbiter: register map,
// status bit positions and the controller state encoding.
package uart_pkg;

    localparam logic [4:0] RX_OFS     = 5'd0;
    localparam logic [4:0] TX_OFS     = 5'd4;
    localparam logic [4:0] STATUS_OFS = 5'd8;

    localparam int TX_OK_POS = 6;
    localparam int RX_OK_POS = 7;

    typedef enum logic [1:0] {
        POLL   = 2'd0,
        DECIDE = 2'd1,
        RD_RX  = 2'd2,
        WR_TX  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the client not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;  // 1: client 1 was granted most recently

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (advance && (grant != 2'b00))
            last <= grant[1];
    end

endmodule

// File: rtl/uart_mm_arbiter.sv
// Polls the UART status register and moves bytes between two TX clients,
// the UART data registers and a one-entry RX buffer over Avalon-MM.
module uart_mm_arbiter
    import uart_pkg::*;
#(
    parameter logic [4:0] RX_BASE     = RX_OFS,
    parameter logic [4:0] TX_BASE     = TX_OFS,
    parameter logic [4:0] STATUS_BASE = STATUS_OFS,
    parameter int         TX_OK_BIT   = TX_OK_POS,
    parameter int         RX_OK_BIT   = RX_OK_POS
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        tx0_valid,
    input  logic [7:0]  tx0_data,
    output logic        tx0_ready,
    input  logic        tx1_valid,
    input  logic [7:0]  tx1_data,
    output logic        tx1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);

    state_t      state, state_n;
    logic        rx_ok_q, tx_ok_q;
    logic [1:0]  grant;
    logic        take_tx;
    logic        rd_done, wr_done;
    logic        read_n, write_n;
    logic [4:0]  addr_n;
    logic [31:0] wdata_n;

    assign rd_done = avm_read  && !avm_waitrequest;
    assign wr_done = avm_write && !avm_waitrequest;

    rr_arb2 u_arb (
        .clk     (avm_clk),
        .rst     (avm_rst),
        .req     ({tx1_valid, tx0_valid}),
        .advance (take_tx),
        .grant   (grant)
    );

    // Ready is only offered in DECIDE, so a client handshake coincides
    // with the byte being captured into the write-data register.
    assign tx0_ready = take_tx && grant[0];
    assign tx1_ready = take_tx && grant[1];

    always_comb begin
        state_n = state;
        take_tx = 1'b0;
        case (state)
            POLL:   if (rd_done) state_n = DECIDE;
            DECIDE: begin
                if (rx_ok_q && !rx_valid) begin
                    state_n = RD_RX;
                end else if (tx_ok_q && (tx0_valid || tx1_valid)) begin
                    state_n = WR_TX;
                    take_tx = 1'b1;
                end else begin
                    state_n = POLL;
                end
            end
            RD_RX:  if (rd_done) state_n = POLL;
            WR_TX:  if (wr_done) state_n = POLL;
            default: state_n = POLL;
        endcase

        // Bus outputs are a function of the next state so they are
        // registered and hold while waitrequest keeps the state put.
        read_n  = (state_n == POLL) || (state_n == RD_RX);
        write_n = (state_n == WR_TX);
        case (state_n)
            RD_RX:   addr_n = RX_BASE;
            WR_TX:   addr_n = TX_BASE;
            default: addr_n = STATUS_BASE;
        endcase
        wdata_n = avm_writedata;
        if (take_tx)
            wdata_n = {24'b0, grant[1] ? tx1_data : tx0_data};
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst)
            state <= POLL;
        else
            state <= state_n;
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= STATUS_BASE;
            avm_writedata <= 32'b0;
            rx_ok_q       <= 1'b0;
            tx_ok_q       <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= 8'b0;
            tx_count      <= 16'b0;
            rx_count      <= 16'b0;
        end else begin
            avm_read      <= read_n;
            avm_write     <= write_n;
            avm_address   <= addr_n;
            avm_writedata <= wdata_n;

            if (state == POLL && rd_done) begin
                rx_ok_q <= avm_readdata[RX_OK_BIT];
                tx_ok_q <= avm_readdata[TX_OK_BIT];
            end

            if (state == WR_TX && wr_done)
                tx_count <= tx_count + 16'd1;

            // RD_RX is only entered with the buffer empty.
            if (state == RD_RX && rd_done) begin
                rx_data  <= avm_readdata[7:0];
                rx_valid <= 1'b1;
                rx_count <= rx_count + 16'd1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mm_arbiter.sv
// Directed scoreboard bench for uart_mm_arbiter with a simple UART slave model.
module tb_uart_mm_arbiter;

    localparam logic [4:0] A_RX = 5'd0, A_TX = 5'd4, A_ST = 5'd8;

    logic        avm_clk, avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest;
    logic        tx0_valid, tx0_ready, tx1_valid, tx1_ready;
    logic [7:0]  tx0_data, tx1_data;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic [15:0] tx_count, rx_count;

    uart_mm_arbiter dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
        .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] rx_q[$];

    int tests = 0, fails = 0;
    int n0 = 0, n1 = 0, stall = 0;
    bit stall_rx = 0;
    logic [7:0] status_val = 8'h00, rx_byte = 8'h00;
    int cyc = 0, last_wr_cyc = 0, last_gap = 0;
    int pulse0 = 0, pulse1 = 0, wr_waits = 0;

    initial begin
        avm_clk = 1'b0;
        forever #5 avm_clk = ~avm_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART slave and TX clients
    initial begin
        bit hs0, hs1;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        tx0_valid       = 1'b0;
        tx1_valid       = 1'b0;
        forever begin
            @(negedge avm_clk);
            avm_waitrequest = 1'b0;
            if (stall > 0 && ((!stall_rx && avm_write === 1'b1) ||
                              (stall_rx && avm_read === 1'b1 && avm_address === A_RX))) begin
                avm_waitrequest = 1'b1;
                stall--;
            end
            avm_readdata = (avm_address === A_ST) ? {24'b0, status_val} : {24'b0, rx_byte};
            hs0 = tx0_valid && (tx0_ready === 1'b1);
            hs1 = tx1_valid && (tx1_ready === 1'b1);
            @(posedge avm_clk); #1;
            if (hs0 && n0 > 0) n0--;
            if (hs1 && n1 > 0) n1--;
            tx0_valid = (n0 > 0);
            tx1_valid = (n1 > 0);
        end
    end

    // Monitor: pops the scoreboard on every completed data access
    initial begin
        logic        p_pend, p_rst, p_rd, p_wr;
        logic [4:0]  p_addr;
        logic [31:0] p_data;
        txn_t        e;
        p_pend = 0; p_rst = 1;
        p_rd = 0; p_wr = 0; p_addr = 0; p_data = 0;
        forever begin
            @(negedge avm_clk); #2;
            cyc++;
            if (avm_read === 1'b1 && avm_write === 1'b1) chk("rw_exclusive", 1, 0);
            if (p_pend && !p_rst) begin
                chk("stable_addr", avm_address, p_addr);
                chk("stable_rdwr", {avm_read, avm_write}, {p_rd, p_wr});
                chk("stable_wdata", avm_writedata, p_data);
            end
            if (tx0_ready === 1'b1) pulse0++;
            if (tx1_ready === 1'b1) pulse1++;
            if (avm_write === 1'b1 && avm_waitrequest) wr_waits++;
            if (avm_write === 1'b1 && !avm_waitrequest) begin
                last_gap    = cyc - last_wr_cyc;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_write", avm_writedata, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("txn_kind_wr", 1, {31'b0, e.wr});
                    chk("wr_addr", avm_address, e.addr);
                    chk("wr_data", avm_writedata, e.data);
                end
            end
            if (avm_read === 1'b1 && avm_address === A_RX && !avm_waitrequest) begin
                if (exp_q.size() == 0) chk("unexpected_rx_read", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("txn_kind_rd", 0, {31'b0, e.wr});
                end
            end
            if (rx_valid === 1'b1 && rx_ready) begin
                if (rx_q.size() == 0) chk("unexpected_rx_byte", rx_data, 32'h1FF);
                else chk("rx_byte", rx_data, rx_q.pop_front());
            end
            p_pend = (avm_read === 1'b1 || avm_write === 1'b1) && avm_waitrequest;
            p_rst  = avm_rst;
            p_rd = avm_read; p_wr = avm_write; p_addr = avm_address; p_data = avm_writedata;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge avm_clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_read"}, avm_read, 0);
        chk({tag, "_write"}, avm_write, 0);
        chk({tag, "_addr"}, avm_address, A_ST);
        chk({tag, "_wdata"}, avm_writedata, 0);
        chk({tag, "_readies"}, {tx0_ready, tx1_ready}, 0);
        chk({tag, "_rx"}, {rx_valid, rx_data}, 0);
        chk({tag, "_counts"}, {tx_count, rx_count}, 0);
    endtask

    task automatic do_reset(input string tag);
        n0 = 0; n1 = 0; stall = 0; stall_rx = 0; rx_ready = 0; status_val = 8'h00;
        avm_rst = 1'b1;
        cycles(2);
        chk_reset_state(tag);
        avm_rst = 1'b0;
        cycles(1);
        chk({tag, "_first_poll"}, {avm_read, avm_write, 3'b0, avm_address}, {2'b10, 3'b0, A_ST});
        pulse0 = 0; pulse1 = 0; wr_waits = 0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cycles(1);
            n++;
        end
        chk({tag, "_timeout"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        avm_rst = 1'b1; rx_ready = 1'b0; tx0_data = 8'h00; tx1_data = 8'h00;

        // single client write
        do_reset("rst0");
        status_val = 8'h40; tx0_data = 8'h41;
        exp_q.push_back('{1'b1, A_TX, 32'h41});
        n0 = 1;
        wait_idle("single", 60);
        cycles(10);
        chk("single_tx_count", tx_count, 1);
        chk("single_pulses", {pulse0[15:0], pulse1[15:0]}, {16'd1, 16'd0});

        // round-robin alternation with both clients valid
        do_reset("rst1");
        status_val = 8'h40; tx0_data = 8'hA0; tx1_data = 8'hB0;
        exp_q.push_back('{1'b1, A_TX, 32'hA0});
        exp_q.push_back('{1'b1, A_TX, 32'hB0});
        exp_q.push_back('{1'b1, A_TX, 32'hA0});
        exp_q.push_back('{1'b1, A_TX, 32'hB0});
        n0 = 2; n1 = 2;
        wait_idle("rr", 100);
        chk("rr_loop_cycles", last_gap, 3);
        cycles(5);
        chk("rr_tx_count", tx_count, 4);

        // RX priority over TX
        do_reset("rst2");
        rx_byte = 8'h55; tx0_data = 8'h42;
        exp_q.push_back('{1'b0, A_RX, 32'h0});
        exp_q.push_back('{1'b1, A_TX, 32'h42});
        rx_q.push_back(8'h55);
        status_val = 8'hC0; n0 = 1;
        wait_idle("prio", 60);
        cycles(5);
        chk("prio_rx_hold", {rx_valid, rx_data}, {1'b1, 8'h55});
        chk("prio_counts", {tx_count, rx_count}, {16'd1, 16'd1});
        status_val = 8'h00;
        cycles(4);
        rx_ready = 1'b1; cycles(1); rx_ready = 1'b0;
        cycles(2);
        chk("prio_rx_drained", rx_valid, 0);

        // full RX buffer blocks further reads
        do_reset("rst3");
        rx_byte = 8'h11;
        exp_q.push_back('{1'b0, A_RX, 32'h0});
        rx_q.push_back(8'h11);
        status_val = 8'h80;
        wait_idle("full1", 60);
        cycles(20);
        chk("full_hold", {rx_valid, rx_data}, {1'b1, 8'h11});
        chk("full_rx_count", rx_count, 1);
        rx_byte = 8'h22;
        exp_q.push_back('{1'b0, A_RX, 32'h0});
        rx_q.push_back(8'h22);
        rx_ready = 1'b1; cycles(1); rx_ready = 1'b0;
        wait_idle("full2", 60);
        cycles(3);
        chk("full_second", {rx_valid, rx_data}, {1'b1, 8'h22});
        chk("full_rx_count2", rx_count, 2);
        status_val = 8'h00;
        cycles(4);
        rx_ready = 1'b1; cycles(1); rx_ready = 1'b0;

        // five wait states on a TX write
        do_reset("rst4");
        status_val = 8'h40; tx0_data = 8'h77;
        stall_rx = 0; stall = 5;
        exp_q.push_back('{1'b1, A_TX, 32'h77});
        n0 = 1;
        wait_idle("wait", 80);
        cycles(5);
        chk("wait_cycles", wr_waits, 5);
        chk("wait_tx_count", tx_count, 1);

        // reset while an RX read is stalled
        do_reset("rst5");
        rx_byte = 8'h99; stall_rx = 1; stall = 1000;
        status_val = 8'h80;
        begin
            int n = 0;
            while (!(avm_read === 1'b1 && avm_address === A_RX) && n < 50) begin
                cycles(1);
                n++;
            end
            chk("abort_reached_rd_rx", {avm_read, 3'b0, avm_address}, {1'b1, 3'b0, A_RX});
        end
        cycles(2);
        avm_rst = 1'b1;
        cycles(1);
        chk_reset_state("abort");
        stall = 0; status_val = 8'h00;
        avm_rst = 1'b0;
        cycles(1);
        chk("abort_first_poll", {avm_read, avm_write, 3'b0, avm_address}, {2'b10, 3'b0, A_ST});
        cycles(10);
        chk("abort_rx_empty", {rx_valid, rx_count}, 0);

        chk("final_rx_queue", rx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
